// File: rtl/regfile_mp.sv
// regfile_mp -- multi-port integer register file with producer scoreboard.
//
// Serves NRD operand reads and NWR retire writes every cycle. Read data,
// per-port busy flags and the busy_any drain indicator are all registered,
// so a read address sampled on edge N produces its result just after edge N
// and holds it until edge N+1.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   rd_addr      NRD read addresses, port k at [k*AW +: AW]
//   rd_data      NRD registered read data, port k at [k*XLEN +: XLEN]
//   rd_busy      NRD registered scoreboard bits of the read addresses
//   wr_en        NWR write enables (higher index = higher priority)
//   wr_addr      NWR write addresses
//   wr_data      NWR write data words
//   sb_set_en    mark sb_set_addr busy (instruction issued)
//   sb_set_addr  destination register being issued
//   busy_any     registered OR of every scoreboard bit
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int AW       = $clog2(NREG),
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*XLEN-1:0]  rd_data,
    output logic [NRD-1:0]       rd_busy,
    input  logic [NWR-1:0]       wr_en,
    input  logic [NWR*AW-1:0]    wr_addr,
    input  logic [NWR*XLEN-1:0]  wr_data,
    input  logic                 sb_set_en,
    input  logic [AW-1:0]        sb_set_addr,
    output logic                 busy_any
);

    logic [XLEN-1:0]      mem_q [NREG];
    logic [XLEN-1:0]      mem_d [NREG];
    logic [NREG-1:0]      busy_q;
    logic [NREG-1:0]      busy_d;
    logic [NRD*XLEN-1:0]  rd_data_q;
    logic [NRD*XLEN-1:0]  rd_data_d;
    logic [NRD-1:0]       rd_busy_q;
    logic [NRD-1:0]       rd_busy_d;
    logic                 busy_any_q;
    logic                 busy_any_d;

    // True when the address names the hard-wired zero register.
    function automatic logic is_hard_zero(input logic [AW-1:0] addr);
        return (ZERO_REG != 0) && (addr == {AW{1'b0}});
    endfunction

    // Next register and scoreboard state. Ports are applied in ascending
    // order so the highest-index port on a shared address lands last and
    // wins. The issue set is applied after all write clears so that a
    // same-edge set beats the clear of the retiring producer.
    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        for (int j = 0; j < NWR; j++) begin
            mem_d[wr_addr[j*AW +: AW]] =
                (wr_en[j] && !is_hard_zero(wr_addr[j*AW +: AW]))
                    ? wr_data[j*XLEN +: XLEN]
                    : mem_d[wr_addr[j*AW +: AW]];
            busy_d[wr_addr[j*AW +: AW]] =
                wr_en[j] ? 1'b0 : busy_d[wr_addr[j*AW +: AW]];
        end
        busy_d[sb_set_addr] =
            (sb_set_en && !is_hard_zero(sb_set_addr)) ? 1'b1 : busy_d[sb_set_addr];
    end

    // Next read outputs. Write-through picks the post-write array; read-first
    // picks the pre-write array. Busy flags always reflect this edge's updates.
    always_comb begin
        rd_data_d = {(NRD*XLEN){1'b0}};
        rd_busy_d = {NRD{1'b0}};
        for (int k = 0; k < NRD; k++) begin
            if (is_hard_zero(rd_addr[k*AW +: AW])) begin
                rd_data_d[k*XLEN +: XLEN] = {XLEN{1'b0}};
            end else if (BYPASS != 0) begin
                rd_data_d[k*XLEN +: XLEN] = mem_d[rd_addr[k*AW +: AW]];
            end else begin
                rd_data_d[k*XLEN +: XLEN] = mem_q[rd_addr[k*AW +: AW]];
            end
            rd_busy_d[k] = busy_d[rd_addr[k*AW +: AW]];
        end
        busy_any_d = |busy_d;
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= {XLEN{1'b0}};
            end
            busy_q     <= {NREG{1'b0}};
            rd_data_q  <= {(NRD*XLEN){1'b0}};
            rd_busy_q  <= {NRD{1'b0}};
            busy_any_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            busy_q     <= busy_d;
            rd_data_q  <= rd_data_d;
            rd_busy_q  <= rd_busy_d;
            busy_any_q <= busy_any_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_busy  = rd_busy_q;
    assign busy_any = busy_any_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a default write-through build (u_a) and a
// 64-bit/16-reg/3-read/1-write read-first build (u_b), each tracked by an
// array model with a per-cycle compare process, plus directed literal checks.
module tb_regfile_mp;

    logic clk;
    logic rst;

    // Build A: XLEN 32, NREG 32, NRD 2, NWR 2, ZERO_REG 1, BYPASS 1
    logic [9:0]  a_rd_addr;
    logic [63:0] a_rd_data;
    logic [1:0]  a_rd_busy;
    logic [1:0]  a_wr_en;
    logic [9:0]  a_wr_addr;
    logic [63:0] a_wr_data;
    logic        a_sb_set_en;
    logic [4:0]  a_sb_set_addr;
    logic        a_busy_any;

    // Build B: XLEN 64, NREG 16, NRD 3, NWR 1, ZERO_REG 1, BYPASS 0
    logic [11:0]  b_rd_addr;
    logic [191:0] b_rd_data;
    logic [2:0]   b_rd_busy;
    logic [0:0]   b_wr_en;
    logic [3:0]   b_wr_addr;
    logic [63:0]  b_wr_data;
    logic         b_sb_set_en;
    logic [3:0]   b_sb_set_addr;
    logic         b_busy_any;

    int checks = 0;
    int errors = 0;

    // Reference state and expected outputs
    logic [31:0] ma_mem [32];
    logic [31:0] ma_busy;
    logic [63:0] mb_mem [16];
    logic [15:0] mb_busy;
    logic [31:0] exp_a_rd_data [2];
    logic        exp_a_rd_busy [2];
    logic        exp_a_busy_any;
    logic [63:0] exp_b_rd_data [3];
    logic        exp_b_rd_busy [3];
    logic        exp_b_busy_any;

    regfile_mp u_a (
        .clk(clk), .rst(rst),
        .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .sb_set_en(a_sb_set_en), .sb_set_addr(a_sb_set_addr),
        .busy_any(a_busy_any)
    );

    regfile_mp #(.XLEN(64), .NREG(16), .NRD(3), .NWR(1), .ZERO_REG(1), .BYPASS(0)) u_b (
        .clk(clk), .rst(rst),
        .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .sb_set_en(b_sb_set_en), .sb_set_addr(b_sb_set_addr),
        .busy_any(b_busy_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Model A: writes in port order (later port overrides), r0 never stored,
    // set applied after clears, reads see the post-write array.
    task automatic model_a();
        logic [31:0] nm [32];
        logic [31:0] nb;
        logic [4:0]  ad;
        if (!rst) begin
            for (int i = 0; i < 32; i++) ma_mem[i] = 32'h0;
            ma_busy = 32'h0;
            for (int k = 0; k < 2; k++) begin
                exp_a_rd_data[k] = 32'h0;
                exp_a_rd_busy[k] = 1'b0;
            end
            exp_a_busy_any = 1'b0;
            return;
        end
        nm = ma_mem;
        nb = ma_busy;
        for (int j = 0; j < 2; j++) begin
            if (a_wr_en[j]) begin
                ad = a_wr_addr[j*5 +: 5];
                if (ad != 5'd0) nm[ad] = a_wr_data[j*32 +: 32];
                nb[ad] = 1'b0;
            end
        end
        if (a_sb_set_en && a_sb_set_addr != 5'd0) nb[a_sb_set_addr] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            ad = a_rd_addr[k*5 +: 5];
            exp_a_rd_data[k] = nm[ad];
            exp_a_rd_busy[k] = nb[ad];
        end
        exp_a_busy_any = (nb != 32'h0);
        ma_mem  = nm;
        ma_busy = nb;
    endtask

    // Model B: same rules, but reads return the array as it was before the edge.
    task automatic model_b();
        logic [63:0] nm [16];
        logic [15:0] nb;
        logic [3:0]  ad;
        if (!rst) begin
            for (int i = 0; i < 16; i++) mb_mem[i] = 64'h0;
            mb_busy = 16'h0;
            for (int k = 0; k < 3; k++) begin
                exp_b_rd_data[k] = 64'h0;
                exp_b_rd_busy[k] = 1'b0;
            end
            exp_b_busy_any = 1'b0;
            return;
        end
        nm = mb_mem;
        nb = mb_busy;
        if (b_wr_en[0]) begin
            if (b_wr_addr != 4'd0) nm[b_wr_addr] = b_wr_data;
            nb[b_wr_addr] = 1'b0;
        end
        if (b_sb_set_en && b_sb_set_addr != 4'd0) nb[b_sb_set_addr] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ad = b_rd_addr[k*4 +: 4];
            exp_b_rd_data[k] = mb_mem[ad];
            exp_b_rd_busy[k] = nb[ad];
        end
        exp_b_busy_any = (nb != 16'h0);
        mb_mem  = nm;
        mb_busy = nb;
    endtask

    // Inputs are set at a negedge; the models predict the next posedge.
    task automatic tick();
        model_a();
        model_b();
        @(negedge clk);
    endtask

    task automatic idle();
        a_wr_en = 2'b00; a_sb_set_en = 1'b0;
        b_wr_en = 1'b0;  b_sb_set_en = 1'b0;
    endtask

    task automatic a_wr(input int j, input logic [4:0] ad, input logic [31:0] d);
        a_wr_en[j] = 1'b1;
        a_wr_addr[j*5 +: 5] = ad;
        a_wr_data[j*32 +: 32] = d;
    endtask

    task automatic a_rd(input int k, input logic [4:0] ad);
        a_rd_addr[k*5 +: 5] = ad;
    endtask

    // Per-cycle comparison of both builds against their models.
    always @(posedge clk) begin
        #2;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("a_rd_data%0d", k), 64'(a_rd_data[k*32 +: 32]), 64'(exp_a_rd_data[k]));
            chk($sformatf("a_rd_busy%0d", k), 64'(a_rd_busy[k]), 64'(exp_a_rd_busy[k]));
        end
        chk("a_busy_any", 64'(a_busy_any), 64'(exp_a_busy_any));
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("b_rd_data%0d", k), b_rd_data[k*64 +: 64], exp_b_rd_data[k]);
            chk($sformatf("b_rd_busy%0d", k), 64'(b_rd_busy[k]), 64'(exp_b_rd_busy[k]));
        end
        chk("b_busy_any", 64'(b_busy_any), 64'(exp_b_busy_any));
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            exp_a_rd_data[k] = 32'h0; exp_a_rd_busy[k] = 1'b0;
        end
        for (int k = 0; k < 3; k++) begin
            exp_b_rd_data[k] = 64'h0; exp_b_rd_busy[k] = 1'b0;
        end
        exp_a_busy_any = 1'b0; exp_b_busy_any = 1'b0;
        a_rd_addr = 10'h0; a_wr_addr = 10'h0; a_wr_data = 64'h0;
        a_sb_set_addr = 5'd0; b_rd_addr = 12'h0; b_wr_addr = 4'd0;
        b_wr_data = 64'h0; b_sb_set_addr = 4'd0;
        idle();
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (2) tick();
        chk("reset_rd_data", a_rd_data, 64'h0);
        chk("reset_busy_any", 64'(a_busy_any), 64'h0);
        chk("reset_b_rd_data", b_rd_data[63:0], 64'h0);

        // Reset: write r5, set r6 busy, then async reset mid-cycle
        rst = 1'b1;
        a_wr(0, 5'd5, 32'hDEADBEEF); a_rd(0, 5'd5);
        tick();
        chk("t1_write_r5", 64'(a_rd_data[31:0]), 64'hDEADBEEF);
        idle();
        a_sb_set_en = 1'b1; a_sb_set_addr = 5'd6; a_rd(1, 5'd6);
        tick();
        chk("t1_busy_r6", 64'(a_rd_busy[1]), 64'h1);
        chk("t1_busy_any", 64'(a_busy_any), 64'h1);
        idle();
        #2 rst = 1'b0;
        #1;
        chk("t1_async_rd_data", a_rd_data, 64'h0);
        chk("t1_async_rd_busy", 64'(a_rd_busy), 64'h0);
        chk("t1_async_busy_any", 64'(a_busy_any), 64'h0);
        model_a(); model_b();
        @(negedge clk);
        tick();
        rst = 1'b1;
        a_rd(0, 5'd5);
        tick();
        chk("t1_r5_after_reset", 64'(a_rd_data[31:0]), 64'h0);

        // Collision and parallel writes
        a_wr(0, 5'd7, 32'h11111111); a_wr(1, 5'd7, 32'h22222222); a_rd(0, 5'd7);
        tick();
        chk("t2_collision_r7", 64'(a_rd_data[31:0]), 64'h22222222);
        a_wr(0, 5'd3, 32'h33333333); a_wr(1, 5'd4, 32'h44444444);
        a_rd(0, 5'd3); a_rd(1, 5'd4);
        tick();
        chk("t2_parallel_r3", 64'(a_rd_data[31:0]), 64'h33333333);
        chk("t2_parallel_r4", 64'(a_rd_data[63:32]), 64'h44444444);
        idle();

        // Write-through on A, read-first on B
        a_wr(1, 5'd9, 32'hA5A5A5A5); a_rd(0, 5'd9); a_rd(1, 5'd7);
        b_wr_en = 1'b1; b_wr_addr = 4'd9; b_wr_data = 64'h0123456789ABCDEF;
        b_rd_addr[3:0] = 4'd9;
        tick();
        chk("t3_bypass_r9", 64'(a_rd_data[31:0]), 64'hA5A5A5A5);
        chk("t3_r7_held", 64'(a_rd_data[63:32]), 64'h22222222);
        chk("t3_readfirst_old", b_rd_data[63:0], 64'h0);
        idle();
        tick();
        chk("t3_readfirst_new", b_rd_data[63:0], 64'h0123456789ABCDEF);

        // Register zero ignores writes and scoreboard sets
        a_wr(0, 5'd0, 32'hFFFFFFFF); a_wr(1, 5'd0, 32'hFFFFFFFF);
        a_sb_set_en = 1'b1; a_sb_set_addr = 5'd0; a_rd(0, 5'd0); a_rd(1, 5'd0);
        tick();
        chk("t4_x0_data", a_rd_data, 64'h0);
        chk("t4_x0_busy", 64'(a_rd_busy), 64'h0);
        chk("t4_x0_busy_any", 64'(a_busy_any), 64'h0);
        idle();

        // Scoreboard set, clear, and set beating clear
        a_sb_set_en = 1'b1; a_sb_set_addr = 5'd12; a_rd(0, 5'd12);
        tick();
        chk("t5_set_busy", 64'(a_rd_busy[0]), 64'h1);
        chk("t5_set_busy_any", 64'(a_busy_any), 64'h1);
        idle();
        a_wr(0, 5'd12, 32'h0000C0C0);
        tick();
        chk("t5_clear_busy", 64'(a_rd_busy[0]), 64'h0);
        chk("t5_clear_busy_any", 64'(a_busy_any), 64'h0);
        idle();
        a_wr(1, 5'd12, 32'h0000C1C1); a_sb_set_en = 1'b1; a_sb_set_addr = 5'd12;
        tick();
        chk("t5_set_wins", 64'(a_rd_busy[0]), 64'h1);
        chk("t5_set_wins_data", 64'(a_rd_data[31:0]), 64'h0000C1C1);
        idle();
        tick();
        chk("t5_busy_held", 64'(a_busy_any), 64'h1);

        // Random traffic on both builds, checked every cycle against the models
        for (int n = 0; n < 3000; n++) begin
            a_wr_en       = 2'($urandom_range(0, 3));
            a_wr_addr     = {5'($urandom_range(0, 15)), 5'($urandom_range(0, 15))};
            a_wr_data     = {32'($urandom), 32'($urandom)};
            a_rd_addr     = {5'($urandom_range(0, 15)), 5'($urandom_range(0, 15))};
            a_sb_set_en   = ($urandom_range(0, 3) == 0);
            a_sb_set_addr = 5'($urandom_range(0, 15));
            b_wr_en       = 1'($urandom_range(0, 1));
            b_wr_addr     = 4'($urandom_range(0, 15));
            b_wr_data     = {32'($urandom), 32'($urandom)};
            b_rd_addr     = 12'($urandom_range(0, 4095));
            b_sb_set_en   = ($urandom_range(0, 3) == 0);
            b_sb_set_addr = 4'($urandom_range(0, 15));
            tick();
        end
        idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
